// File: rtl/fetcher_pkg.sv
// Shared types for the fetch stage: word types, fetch FSM states and the IF/ID pipeline register.
package fetcher_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRAIN,
      BUF
   } FETCH_STATE;

   typedef struct packed {
      logic valid;
      u64   pc;
      u64   pcPlus4;
      u32   instr;
      u64   instrAddr;
   } REG_IF_ID;

   function automatic REG_IF_ID make_if_id(input u64 pc, input u32 instr);
      REG_IF_ID r;
      r.valid     = 1'b1;
      r.pc        = pc;
      r.pcPlus4   = pc + 64'd4;
      r.instr     = instr;
      r.instrAddr = pc;
      return r;
   endfunction

endpackage

// File: rtl/fetcher.sv
// IF stage: owns the PC, issues instruction-bus reads and drives the IF/ID register.
// Redirects never wait for memory; a response in flight at redirect time is drained and dropped.
module fetcher
   import fetcher_pkg::*;
#(
   parameter u64 RESET_PC = 64'h8000_0000
) (
   input  logic     clk,
   input  logic     rst_n,
   output logic     ireq_valid,
   output u64       ireq_addr,
   input  logic     iresp_data_ok,
   input  u64       iresp_data,
   output REG_IF_ID moduleOut,
   input  logic     lwHold,
   input  logic     JumpEn,
   input  u64       jumpTarget,
   output logic     ok_to_proceed,
   input  logic     ok_to_proceed_overall
);

   FETCH_STATE state_q, state_d;
   u64         pc_q, pc_d;
   u64         tgt_q, tgt_d;
   u32         buf_instr_q, buf_instr_d;
   REG_IF_ID   out_q, out_d;

   logic adv;
   u64   tgt_in;
   u64   tgt_next;
   u32   resp_instr;

   always_comb begin
      adv        = ok_to_proceed_overall;
      tgt_in     = jumpTarget & ~64'h3;
      resp_instr = pc_q[2] ? iresp_data[63:32] : iresp_data[31:0];
      // In DRAIN a redirect arriving with the drained response wins over the captured target.
      tgt_next   = (adv && JumpEn) ? tgt_in : tgt_q;

      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      buf_instr_d = buf_instr_q;
      out_d       = out_q;

      unique case (state_q)
         IDLE: state_d = REQ;

         REQ: begin
            if (adv) begin
               if (JumpEn) begin
                  out_d.valid = 1'b0;
                  if (iresp_data_ok) begin
                     pc_d = tgt_in;
                  end else begin
                     tgt_d   = tgt_in;
                     state_d = DRAIN;
                  end
               end else if (!iresp_data_ok) begin
                  out_d.valid = 1'b0;
               end else if (lwHold) begin
                  out_d.valid = 1'b0;
                  buf_instr_d = resp_instr;
                  state_d     = BUF;
               end else begin
                  out_d = make_if_id(pc_q, resp_instr);
                  pc_d  = pc_q + 64'd4;
               end
            end else if (iresp_data_ok) begin
               buf_instr_d = resp_instr;
               state_d     = BUF;
            end
         end

         DRAIN: begin
            tgt_d = tgt_next;
            if (adv) out_d.valid = 1'b0;
            if (iresp_data_ok) begin
               pc_d    = tgt_next;
               state_d = REQ;
            end
         end

         BUF: begin
            if (adv) begin
               if (JumpEn) begin
                  out_d.valid = 1'b0;
                  pc_d        = tgt_in;
                  state_d     = REQ;
               end else if (lwHold) begin
                  out_d.valid = 1'b0;
               end else begin
                  out_d   = make_if_id(pc_q, buf_instr_q);
                  pc_d    = pc_q + 64'd4;
                  state_d = REQ;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ireq_valid = (state_q == REQ) || (state_q == DRAIN);
      ireq_addr  = pc_q & ~64'h7;
      moduleOut  = out_q;
      if (state_q == IDLE) begin
         ok_to_proceed = 1'b0;
      end else begin
         ok_to_proceed = JumpEn || lwHold || (state_q == BUF) ||
                         ((state_q == REQ) && iresp_data_ok);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         tgt_q       <= '0;
         buf_instr_q <= '0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         tgt_q       <= tgt_d;
         buf_instr_q <= buf_instr_d;
         out_q       <= out_d;
      end
   end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: a latency-configurable instruction memory plus a scoreboard of
// expected hand-off PCs, compared whenever the stage advances with a valid IF/ID entry.
module tb_fetcher;
   import fetcher_pkg::*;

   logic     clk = 1'b0;
   logic     rst_n;
   logic     ireq_valid;
   u64       ireq_addr;
   logic     iresp_data_ok;
   u64       iresp_data;
   REG_IF_ID moduleOut;
   logic     lwHold;
   logic     JumpEn;
   u64       jumpTarget;
   logic     ok_to_proceed;
   logic     ok_to_proceed_overall;
   logic     adv_en;

   // The bench plays the rest of the pipeline: global advance is IF's readiness gated by adv_en.
   assign ok_to_proceed_overall = ok_to_proceed & adv_en;

   always #5 clk = ~clk;

   fetcher #(.RESET_PC(64'h8000_0000)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .ireq_valid            (ireq_valid),
      .ireq_addr             (ireq_addr),
      .iresp_data_ok         (iresp_data_ok),
      .iresp_data            (iresp_data),
      .moduleOut             (moduleOut),
      .lwHold                (lwHold),
      .JumpEn                (JumpEn),
      .jumpTarget            (jumpTarget),
      .ok_to_proceed         (ok_to_proceed),
      .ok_to_proceed_overall (ok_to_proceed_overall)
   );

   int       n_checks = 0;
   int       n_errors = 0;
   u64       exp_q[$];
   int       lat = 1;
   int       cnt = 0;
   int       resp_count = 0;
   u64       pend_addr = '0;
   logic     seen_200 = 1'b0;
   REG_IF_ID prev_out = '0;
   logic     adv_e;
   logic     dok_e;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic u32 instr_of(input u64 a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_C3C3;
   endfunction

   function automatic u64 dw_of(input u64 a);
      u64 base;
      base = a & ~64'h7;
      return {instr_of(base | 64'h4), instr_of(base)};
   endfunction

   // One clock: sample advance at negedge, then after the edge score the output and run memory.
   task automatic step();
      u64 e;
      @(negedge clk);
      adv_e = ok_to_proceed_overall;
      dok_e = iresp_data_ok;
      @(posedge clk);
      #1;
      if (adv_e) begin
         if (moduleOut.valid) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_valid", 64'(moduleOut.valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("out_pc", moduleOut.pc, e);
               check_eq("out_instr_addr", moduleOut.instrAddr, e);
               check_eq("out_pc_plus4", moduleOut.pcPlus4, e + 64'd4);
               check_eq("out_instr", 64'(moduleOut.instr), 64'(instr_of(e)));
            end
         end
      end else begin
         check_eq("hold_out", 64'(moduleOut == prev_out), 64'd1);
      end
      prev_out = moduleOut;

      if (dok_e) begin
         iresp_data_ok = 1'b0;
         cnt           = 0;
         resp_count++;
      end
      if (ireq_valid) begin
         if (ireq_addr == 64'h8000_0200) seen_200 = 1'b1;
         if (cnt == 0) pend_addr = ireq_addr;
         else check_eq("addr_stable", ireq_addr, pend_addr);
         cnt++;
         if (cnt >= lat) begin
            iresp_data_ok = 1'b1;
            iresp_data    = dw_of(ireq_addr);
         end
      end else if (cnt > 0) begin
         check_eq("req_dropped", 64'(ireq_valid), 64'd1);
      end
   endtask

   task automatic run_until_empty(input string tag, input int bound);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < bound) begin
         step();
         i++;
      end
      check_eq(tag, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      int saved;
      rst_n         = 1'b1;
      lwHold        = 1'b0;
      JumpEn        = 1'b0;
      jumpTarget    = '0;
      adv_en        = 1'b1;
      iresp_data_ok = 1'b0;
      iresp_data    = '0;
      #2 rst_n = 1'b0;

      repeat (3) begin
         step();
         check_eq("rst_ireq", 64'(ireq_valid), 64'd0);
         check_eq("rst_valid", 64'(moduleOut.valid), 64'd0);
      end
      rst_n = 1'b1;
      #1;
      check_eq("idle_ireq", 64'(ireq_valid), 64'd0);
      check_eq("idle_ok", 64'(ok_to_proceed), 64'd0);
      step();
      check_eq("first_ireq", 64'(ireq_valid), 64'd1);
      check_eq("first_addr", ireq_addr, 64'h8000_0000);

      // Straight-line with a two-advance decoder hold on the instruction at 0x8000_0004.
      exp_q = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};
      i = 0;
      while (exp_q.size() == 4 && i < 10) begin
         step();
         i++;
      end
      check_eq("first_handoff", 64'(exp_q.size()), 64'd3);
      saved  = resp_count;
      lwHold = 1'b1;
      step();
      check_eq("hold_bubble1", 64'(moduleOut.valid), 64'd0);
      check_eq("buf_no_req", 64'(ireq_valid), 64'd0);
      step();
      check_eq("hold_bubble2", 64'(moduleOut.valid), 64'd0);
      lwHold = 1'b0;
      check_eq("no_refetch", 64'(resp_count), 64'(saved + 1));
      run_until_empty("straight", 20);

      // Global stall while the response lands: buffered, bus idle, output frozen.
      exp_q  = '{64'h8000_0010, 64'h8000_0014};
      adv_en = 1'b0;
      repeat (4) begin
         step();
         check_eq("stall_ireq", 64'(ireq_valid), 64'd0);
      end
      check_eq("stall_no_out", 64'(exp_q.size()), 64'd2);
      adv_en = 1'b1;
      run_until_empty("stall", 20);

      // Slow memory so a request is still pending when the redirect arrives.
      lat   = 3;
      exp_q = '{64'h8000_0018, 64'h8000_001C};
      run_until_empty("slow", 20);

      exp_q      = '{64'h8000_0100, 64'h8000_0104};
      JumpEn     = 1'b1;
      jumpTarget = 64'h8000_0103;
      step();
      JumpEn     = 1'b0;
      jumpTarget = '0;
      check_eq("jump_bubble", 64'(moduleOut.valid), 64'd0);
      check_eq("drain_addr", ireq_addr, 64'h8000_0020);
      #1;
      check_eq("drain_stall", 64'(ok_to_proceed), 64'd0);
      i = 0;
      while (ireq_addr == 64'h8000_0020 && i < 10) begin
         step();
         i++;
      end
      check_eq("redirect_addr", ireq_addr, 64'h8000_0100);
      run_until_empty("jump", 30);

      // Two redirects while draining: only the later one is fetched.
      exp_q      = '{64'h8000_0300, 64'h8000_0304};
      JumpEn     = 1'b1;
      jumpTarget = 64'h8000_0200;
      step();
      jumpTarget = 64'h8000_0300;
      step();
      JumpEn     = 1'b0;
      run_until_empty("double_jump", 30);
      check_eq("no_fetch_200", 64'(seen_200), 64'd0);

      // Misaligned redirect to the top of the address space; pc+4 wraps to zero.
      exp_q      = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
      JumpEn     = 1'b1;
      jumpTarget = 64'hFFFF_FFFF_FFFF_FFFE;
      step();
      JumpEn     = 1'b0;
      run_until_empty("wrap", 30);

      // Redirect in the same cycle as data_ok: response dropped, no drain.
      lat = 1;
      i   = 0;
      while (!iresp_data_ok && i < 10) begin
         step();
         i++;
      end
      check_eq("dok_wait", 64'(iresp_data_ok), 64'd1);
      exp_q      = '{64'h8000_0400};
      JumpEn     = 1'b1;
      jumpTarget = 64'h8000_0400;
      step();
      JumpEn     = 1'b0;
      check_eq("jump_hit_bubble", 64'(moduleOut.valid), 64'd0);
      check_eq("jump_hit_addr", ireq_addr, 64'h8000_0400);
      run_until_empty("jump_hit", 10);

      // Redirect out of BUF discards the buffered instruction.
      adv_en = 1'b0;
      step();
      adv_en     = 1'b1;
      exp_q      = '{64'h8000_0500};
      JumpEn     = 1'b1;
      jumpTarget = 64'h8000_0500;
      step();
      JumpEn     = 1'b0;
      check_eq("buf_jump_addr", ireq_addr, 64'h8000_0500);
      run_until_empty("buf_jump", 10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
